seq_1101_frame_tx: RTL and testbench
====================================

# seq_1101_frame_tx

Serial frame transmitter that forms the sending end of the 1101 sequence-detection link. On each accepted request it emits the sync pattern 1101 on a one-bit line, then a DATA_W-bit payload MSB-first, then GAP idle zero bits. Its output drives the overlapping 1101 Moore detector, which fires on the last sync bit. It sits between a parallel data source and the serial line.

## Interface
- DATA_W, 8, payload width in bits; legal range 1..32.
- GAP, 2, number of idle zero bits after each frame before the next can be accepted; legal range 0..15. GAP >= 2 is required to avoid a false sync at the frame boundary.
- clk  in  1  rising-edge clock.
- arstn  in  1  reset, asynchronous and active-low.
- start  in  1  request to send; sampled only while ready=1.
- data_in  in  DATA_W  payload; captured on the edge where start && ready.
- ready  out  1  block is idle and can accept a request.
- seq  out  1  serial line bit.
- seq_valid  out  1  high while a sync or payload bit is on seq.
- done  out  1  one-cycle pulse when the last payload bit has been sent.

## Operation
- Moore FSM with states IDLE, SYNC, DATA, GAP.
- All outputs are registered and depend only on state, bit counter and shift register. There is no combinational path from any input to any output.
- IDLE
  - ready=1, seq=0, seq_valid=0.
  - start=1 captures data_in into the shift register, clears the bit counter and moves to SYNC.
- SYNC
  - seq presents sync bits in order 1, 1, 0, 1, one per cycle; seq_valid=1; ready=0.
  - After the 4th bit, moves to DATA.
- DATA
  - seq presents payload bits data_in[DATA_W-1] down to data_in[0]; seq_valid=1.
  - After the last bit: moves to GAP if GAP>0, otherwise to IDLE.
- GAP
  - seq=0, seq_valid=0, ready=0 for GAP cycles, then moves to IDLE.
- done
  - Asserted for exactly one cycle: the first cycle after the last payload bit, i.e. the first GAP cycle, or the IDLE cycle when GAP=0.
- start is ignored while ready=0. No queuing; the request is lost.
- data_in changes after acceptance have no effect on the frame in flight.
- Bit counter width: $clog2 of max(4, DATA_W, GAP) plus 1. It counts up from 0 and compares to (length-1) in each state, so it never wraps.
- Reset, asynchronous, including mid-frame:
  - Forces IDLE: ready=1, seq=0, seq_valid=0, done=0.
  - Clears the shift register and counter.
  - Aborts the frame with no done pulse.
  - Operation resumes on the first clock edge after arstn deasserts.

## Timing
- Accept on edge k (start=1, ready=1 before the edge).
- Sync bits are valid after edges k, k+1, k+2, k+3.
- Payload bit i (MSB = 0) is valid after edge k+4+i.
- done is high after edge k+4+DATA_W.
- ready returns high after edge k+4+DATA_W+GAP.
- Frame period: 4+DATA_W+GAP cycles.
- With GAP=0, done and ready rise in the same cycle. A start held high then launches the next frame with no idle bit; the sync follows the payload back-to-back.
- A downstream overlapping 1101 detector asserts its output one cycle after seq carries the 4th sync bit. Payload containing 1101 also triggers it; that is a property of the line, not an error.

## Structure
- Shared package seq_1101_pkg:
  - state encoding constants S_IDLE, S_SYNC, S_DATA, S_GAP (2-bit);
  - SYNC_PATTERN = 4'b1101;
  - SYNC_LEN = 4.
- The detector side reuses the same package.
- One sub-module: piso_shift_reg. It is a parameterised parallel-in serial-out register with load, shift and MSB-out ports, and an async active-low clear. It is used for the payload. The sync bits come from indexing SYNC_PATTERN with the counter.

## Test plan
- Reset value: assert arstn=0 for 3 cycles while start=1 and data_in=8'hFF -> ready=1, seq=0, seq_valid=0, done=0; no frame starts while in reset.
- Single frame, DATA_W=8, GAP=2: start pulse with data_in=8'hA5 -> seq = 1101 10100101 00 over 14 cycles; seq_valid high for 12 cycles; done pulse at cycle 13 after accept; ready high at cycle 15.
- Ignored start: hold start=1 for the whole frame with data_in changed to 8'h3C mid-frame -> first frame still sends A5; second frame sends 3C, accepted on the first ready cycle.
- Back-to-back, GAP=0: data 8'h00 then 8'h0D -> continuous 1101 00000000 1101 00001101, no zero idle bit between frames; done coincides with ready.
- Mid-frame reset: pull arstn low during payload bit 3 of 8'hFF -> seq=0 and ready=1 immediately (asynchronously); no done pulse; the next start sends a complete fresh frame.
- Detector loopback: feed seq into the 1101 detector for payload 8'h6D -> detector fires once per frame for the sync, plus at the payload's 1101 occurrences; no firing across the GAP=2 boundary.

Source files
------------

// File: rtl/seq_1101_pkg.sv
// Shared definitions for both ends of the 1101 sequence link.
// The transmitter and the overlapping 1101 detector both import this package.
package seq_1101_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    localparam logic [3:0] SYNC_PATTERN = 4'b1101;
    localparam int         SYNC_LEN     = 4;

    // Counter wide enough for the longest phase plus one bit of headroom.
    function automatic int cnt_width(input int data_w, input int gap);
        int m;
        m = SYNC_LEN;
        if (data_w > m) m = data_w;
        if (gap > m)    m = gap;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/seq_1101_frame_tx_if.sv
// Parallel request side plus serial line of the 1101 frame transmitter.
interface seq_1101_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              seq;
    logic              seq_valid;
    logic              done;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  seq,
        input  seq_valid,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output seq,
        output seq_valid,
        output done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: load a word, then shift it out MSB first.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values; the data register is
    // cleared on reset too, so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_1101_frame_tx.sv
// Serial frame transmitter: sync 1101, DATA_W payload bits MSB first, then GAP idle zeros.
// Outputs decode only from registered state, so no input reaches an output combinationally.
module seq_1101_frame_tx
    import seq_1101_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic                 clk,
    input  logic                 arstn,
    seq_1101_frame_tx_if.slave   bus
);
    localparam int CNT_W = cnt_width(DATA_W, GAP);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load;
    logic             shift;
    logic             payload_bit;
    logic [1:0]       sync_idx;

    piso_shift_reg #(
        .W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .arstn   (arstn),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (bus.data_in),
        .msb_o   (payload_bit)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                shift = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    // done lands in the first GAP cycle, or the IDLE cycle when there is no gap.
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sync bits come straight from the pattern, first bit at the MSB end.
    assign sync_idx = 2'(SYNC_LEN - 1) - cnt_q[1:0];

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.seq_valid = (state_q == S_SYNC) || (state_q == S_DATA);
    assign bus.seq       = (state_q == S_SYNC) ? SYNC_PATTERN[sync_idx]
                         : (state_q == S_DATA) ? payload_bit
                         : 1'b0;
    assign bus.done      = done_q;

    a_valid_not_ready: assert property (@(posedge clk) disable iff (!arstn)
        !(bus.seq_valid && bus.ready));

    a_done_single: assert property (@(posedge clk) disable iff (!arstn)
        bus.done |=> !bus.done);

endmodule

// File: tb/tb_seq_1101_frame_tx.sv
// Scoreboard bench: one transmitter with GAP=2 and one with GAP=0 share the same stimulus.
module tb_seq_1101_frame_tx;
    import seq_1101_pkg::*;

    localparam int DATA_W = 8;
    localparam int NDUT   = 2;

    logic              clk   = 1'b0;
    logic              arstn = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    int checks = 0;
    int errors = 0;
    int det_total = 0;

    logic rdy_w [NDUT];
    logic seq_w [NDUT];
    logic vld_w [NDUT];
    logic done_w[NDUT];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int G     = (g == 0) ? 2 : 0;
        localparam int BUSY  = SYNC_LEN + DATA_W + G;
        localparam int BITS  = SYNC_LEN + DATA_W;

        seq_1101_frame_tx_if #(.DATA_W(DATA_W)) bus ();

        assign bus.start   = start;
        assign bus.data_in = data_in;
        assign rdy_w[g]    = bus.ready;
        assign seq_w[g]    = bus.seq;
        assign vld_w[g]    = bus.seq_valid;
        assign done_w[g]   = bus.done;

        seq_1101_frame_tx #(
            .DATA_W (DATA_W),
            .GAP    (G)
        ) u_dut (
            .clk   (clk),
            .arstn (arstn),
            .bus   (bus.slave)
        );

        // Reference model: age counts edges since the last accepted request.
        int age    = 0;
        bit active = 1'b0;
        bit exp_q[$];

        always @(posedge clk or negedge arstn) begin
            bit idle_now;
            if (!arstn) begin
                active = 1'b0;
                age    = 0;
                exp_q.delete();
            end else begin
                idle_now = !active || (age >= BUSY);
                if (age < 100000) age++;
                if (start && idle_now) begin
                    active = 1'b1;
                    age    = 0;
                    for (int i = 0; i < SYNC_LEN; i++) exp_q.push_back(SYNC_PATTERN[SYNC_LEN-1-i]);
                    for (int i = 0; i < DATA_W; i++)   exp_q.push_back(data_in[DATA_W-1-i]);
                end
            end
        end

        always @(negedge clk) begin
            logic exp_rdy, exp_vld, exp_done;
            exp_rdy  = !active || (age >= BUSY);
            exp_vld  = active && (age < BITS);
            exp_done = active && (age == BITS);
            check($sformatf("ready g%0d", g), bus.ready, exp_rdy);
            check($sformatf("seq_valid g%0d", g), bus.seq_valid, exp_vld);
            check($sformatf("done g%0d", g), bus.done, exp_done);
            if (bus.seq_valid) begin
                if (exp_q.size() == 0) check($sformatf("seq underflow g%0d", g), bus.seq_valid, 1'b0);
                else                   check($sformatf("seq g%0d", g), bus.seq, exp_q.pop_front());
            end else begin
                check($sformatf("seq idle g%0d", g), bus.seq, 1'b0);
            end
        end
    end

    // Behavioural overlapping 1101 Moore detector listening to the GAP=2 line.
    logic [3:0] det_hist = '0;
    logic       det_fire = 1'b0;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            det_hist = '0;
            det_fire = 1'b0;
        end else begin
            det_hist = {det_hist[2:0], seq_w[0]};
            det_fire = (det_hist == SYNC_PATTERN);
        end
    end

    always @(negedge clk) if (det_fire) det_total++;

    task automatic wait_ready(input int g, input int budget);
        int n = 0;
        while (rdy_w[g] !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("ready timeout g%0d", g), rdy_w[g], 1'b1);
    endtask

    task automatic wait_all_idle();
        wait_ready(0, 200);
        wait_ready(1, 200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset held with a pending request: nothing may start.
        arstn = 1'b0; start = 1'b1; data_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst ready g%0d", g), rdy_w[g], 1'b1);
            check($sformatf("rst seq g%0d", g), seq_w[g], 1'b0);
            check($sformatf("rst valid g%0d", g), vld_w[g], 1'b0);
            check($sformatf("rst done g%0d", g), done_w[g], 1'b0);
        end
        start = 1'b0;
        arstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame A5.
        wait_all_idle();
        start = 1'b1; data_in = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;

        // Start held through the frame, data changed mid-frame.
        wait_all_idle();
        start = 1'b1; data_in = 8'hA5;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        data_in = 8'h3C;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        wait_all_idle();

        // Back-to-back 00 then 0D.
        start = 1'b1; data_in = 8'h00;
        @(posedge clk); #1;
        data_in = 8'h0D;
        repeat (13) @(posedge clk);
        #1;
        start = 1'b0;
        wait_all_idle();

        // Asynchronous reset during payload bit 3 of FF.
        start = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        arstn = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("abort ready g%0d", g), rdy_w[g], 1'b1);
            check($sformatf("abort seq g%0d", g), seq_w[g], 1'b0);
            check($sformatf("abort valid g%0d", g), vld_w[g], 1'b0);
            check($sformatf("abort done g%0d", g), done_w[g], 1'b0);
        end
        @(posedge clk); #1;
        arstn = 1'b1;
        start = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_all_idle();

        // Detector loopback: two back-to-back 6D frames on the GAP=2 line.
        repeat (3) @(posedge clk);
        #1;
        base = det_total;
        start = 1'b1; data_in = 8'h6D;
        repeat (16) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("detector fires", det_total - base, 6);
        wait_all_idle();

        // Random traffic with occasional asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (arstn == 1'b0) begin
                arstn = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                arstn = 1'b0;
            end
            start   = ($urandom_range(0, 3) == 0);
            data_in = DATA_W'($urandom);
        end
        start = 1'b0;
        arstn = 1'b1;
        wait_all_idle();
        repeat (3) @(posedge clk);
        #1;
        check("leftover bits g0", g_dut[0].exp_q.size(), 0);
        check("leftover bits g1", g_dut[1].exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
